// File: rtl/rr_arbiter_enc_pkg.sv
// Shared definitions for the round-robin arbiter and the 4:16 line decoder it feeds.
package rr_arbiter_enc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Code 0 means "no line selected" on the decoder input.
  localparam int CODE_NONE = 0;

endpackage

// File: rtl/rr_arbiter_enc_if.sv
// Request/grant bundle between requesters and the arbiter.
interface rr_arbiter_enc_if #(
  parameter int N      = 15,
  parameter int CODE_W = 4
) ();
  logic [N-1:0]      req;
  logic              done;
  logic [CODE_W-1:0] grant_code;
  logic              grant_valid;
  logic              timeout;

  modport master (output req, output done,
                  input grant_code, input grant_valid, input timeout);
  modport slave  (input req, input done,
                  output grant_code, output grant_valid, output timeout);
endinterface

// File: rtl/rr_pick.sv
// Rotating priority find: first set bit of req_i at or above ptr_i, wrapping at N-1.
module rr_pick #(
  parameter int N = 15,
  parameter int W = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);
  int j;

  // Scan from the farthest offset down so the nearest hit is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j]) begin
        found_o = 1'b1;
        idx_o   = W'(j);
      end
    end
  end
endmodule

// File: rtl/rr_arbiter_enc.sv
// Round-robin arbiter producing a registered binary grant code + enable for a line decoder.
module rr_arbiter_enc
  import rr_arbiter_enc_pkg::*;
#(
  parameter int N        = 15,
  parameter int CODE_W   = 4,
  parameter int MAX_HOLD = 255,
  parameter int HOLD_W   = 8
) (
  input logic             clk,
  input logic             rst_n,
  rr_arbiter_enc_if.slave bus
);
  arb_state_e        state_q;
  logic [CODE_W-1:0] code_q, ptr_q;
  logic              valid_q, tmo_q;
  logic [HOLD_W-1:0] hold_q;

  logic              found;
  logic [CODE_W-1:0] idx, owner, ptr_d;
  logic [2**CODE_W-1:0] req_ext;
  logic              owner_req, hit_lim, rel;

  rr_pick #(.N(N), .W(CODE_W)) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .found_o (found),
    .idx_o   (idx)
  );

  // Zero-extend so indexing by owner never leaves the vector.
  assign req_ext   = {{(2**CODE_W-N){1'b0}}, bus.req};
  assign owner     = code_q - CODE_W'(1);
  assign owner_req = req_ext[owner];
  assign hit_lim   = (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign rel       = bus.done | ~owner_req | hit_lim;
  assign ptr_d     = (owner == CODE_W'(N - 1)) ? '0 : owner + CODE_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= CODE_W'(CODE_NONE);
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            code_q  <= idx + CODE_W'(1);
            valid_q <= 1'b1;
            hold_q  <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          hold_q <= hold_q + HOLD_W'(1);
          if (rel) begin
            code_q  <= CODE_W'(CODE_NONE);
            valid_q <= 1'b0;
            ptr_q   <= ptr_d;
            // Forced release only when nothing else explains it.
            tmo_q   <= hit_lim & ~bus.done & owner_req;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant_code  = code_q;
  assign bus.grant_valid = valid_q;
  assign bus.timeout     = tmo_q;
endmodule

// File: doc/rr_arbiter_enc.md
Name: rr_arbiter_enc

Overview:
- Sequential round-robin arbiter for up to 15 requesters.
- Registers a binary grant code plus an enable, and feeds them directly to the codebase's 4:16 line decoder (in = grant_code, enable = grant_valid), which regenerates the one-hot select lines.
- Code convention matches that decoder: code 0 = no line selected; code k selects line k-1.
- Grants are held until the owner signals done, or until a watchdog hold limit expires.

Parameters:
- N, 15, number of requesters; legal range 1..(2**CODE_W)-1.
- CODE_W, 4, grant code width; must equal the downstream decoder input width.
- MAX_HOLD, 255, maximum cycles a grant may be held before forced release; must be >= 1.
- HOLD_W, 8, width of the hold counter; must satisfy 2**HOLD_W > MAX_HOLD.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, reset; asynchronous, active-low.
- req, input, N, request vector; bit i = requester i.
- done, input, 1, single-cycle pulse from the current owner releasing the grant.
- grant_code, output, CODE_W, registered code: 0 = none, i+1 = requester i.
- grant_valid, output, 1, registered enable to the decoder; high exactly when grant_code != 0.
- timeout, output, 1, registered one-cycle pulse on forced release.

Behaviour:
- Reset (rst_n low, asynchronous, any state): grant_code=0, grant_valid=0, timeout=0, state=IDLE, pointer=0, hold count=0.
- Release of reset is sampled synchronously.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, select the first set bit at index >= pointer, searching upward with wrap from N-1 to 0.
  - Next edge: grant_code = idx+1, grant_valid = 1, hold count = 0, go to GRANT.
  - Latency from req high to grant_valid high is 1 cycle.
  - If req == 0, stay in IDLE; outputs remain 0.
- GRANT:
  - Hold count increments each cycle.
  - Release when done=1, OR req[idx]=0 (requester withdrew), OR hold count == MAX_HOLD-1.
  - On release, next edge: grant_code=0, grant_valid=0, pointer = (idx+1) mod N, go to IDLE.
  - A grant therefore lasts at most MAX_HOLD cycles.
  - timeout=1 for one cycle only when release is caused by the hold limit and neither done nor withdrawal is present in that cycle. If done coincides with the limit, done wins and timeout stays 0.
- Mandatory idle bubble: at least one cycle with grant_valid=0 between successive grants, even when other requests are pending. This ensures the decoder output passes through all-zero between owners.
- Simultaneous events:
  - done while in IDLE: ignored.
  - Request changes of non-owners during GRANT: ignored.
  - The owner's request re-asserting in the same cycle as release still counts as released.
- Fairness: with all N requesting continuously, grants cycle 0,1,...,N-1,0,... With N=1, the pointer stays 0.
- Bits of req above N-1 do not exist; grant_code never exceeds N.
- No combinational path from any input to any output.

Decomposition:
- Shared package: state encoding (IDLE, GRANT) and the constant for code 0 = "no select", so the decoder and the arbiter share one definition.
- One sub-module, rr_pick: combinational rotate-and-priority-find taking req and pointer, producing found and idx. It is reusable by later arbiters.
- The FSM, pointer, and hold counter stay in rr_arbiter_enc.

Test Plan:
- Reset mid-grant: grant active with code=3; drop rst_n mid-cycle -> grant_code=0 and grant_valid=0 immediately, without waiting for a clock edge; after release, req=0 keeps outputs at 0.
- Single request: req=0x0004 at cycle t -> at t+1 grant_code=3, grant_valid=1; done pulse at t+5 -> at t+6 grant_code=0; pointer=3.
- Fairness: req=0x7FFF held, done pulsed in each grant cycle -> code sequence 1,0,2,0,3,0,...,15,0,1 (bubble between every grant).
- Wrap: pointer=14, req=0x4001 -> grant code 15, then after release code 1.
- Timeout: MAX_HOLD=4, req=0x0002 held, no done -> grant_valid high for exactly 4 cycles with code 2; timeout pulses 1 cycle at the release edge; the next grant to the same requester occurs only after the bubble.
- Withdrawal and collision: owner drops req -> release next edge with timeout=0; separately, done coinciding with the hold limit -> timeout stays 0.
